// File: rtl/temp_fan_pwm.sv
// Fan controller fed by the DHT11 temperature byte: hysteretic OFF/RUN/FULL banding,
// slew-limited duty and a period-latched PWM; stale or implausible input forces full speed.
module temp_fan_pwm #(
  parameter int unsigned T_ON        = 30,
  parameter int unsigned T_OFF       = 27,
  parameter int unsigned T_FULL      = 40,
  parameter int unsigned HYST_FULL   = 2,
  parameter int unsigned T_MAX       = 60,
  parameter int unsigned MIN_DUTY    = 30,
  parameter int unsigned STEP_PCT    = 7,
  parameter int unsigned PWM_PRESC   = 1000,
  parameter int unsigned RAMP_DIV    = 100000,
  parameter int unsigned STALE_LIMIT = 200000000,
  parameter int unsigned REJ_LIMIT   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TEMP_INT,
  input  logic       TEMP_VALID,
  output logic       FAN_PWM,
  output logic [6:0] DUTY,
  output logic [1:0] STATE_OUT,
  output logic       FAULT
);

  localparam int unsigned STALE_W = $clog2(STALE_LIMIT + 1);
  localparam int unsigned REJ_W   = (REJ_LIMIT > 0) ? $clog2(REJ_LIMIT + 1) : 1;
  localparam int unsigned RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned PRESC_W = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
  localparam logic [7:0]  T_FULL_LO = 8'(T_FULL - HYST_FULL);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FULL  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t               state_reg;
  logic                 fault_reg;
  logic [7:0]           last_temp_reg;
  logic [STALE_W-1:0]   stale_reg, stale_next;
  logic [REJ_W-1:0]     rej_reg, rej_next;
  logic [6:0]           target_reg;
  logic [6:0]           duty_reg;
  logic [RAMP_W-1:0]    ramp_reg;
  logic [PRESC_W-1:0]   presc_reg;
  logic [6:0]           step_reg, step_next;
  logic [6:0]           latch_reg, latch_next;
  logic                 pwm_reg;

  logic                 accept, reject, fault_trip, ramp_tick, presc_tick;
  logic [31:0]          run_calc;
  logic [6:0]           run_duty;

  always_comb begin
    accept = TEMP_VALID && (TEMP_INT <= 8'(T_MAX));
    reject = TEMP_VALID && !accept;

    if (accept)
      stale_next = '0;
    else if (stale_reg == STALE_W'(STALE_LIMIT))
      stale_next = stale_reg;
    else
      stale_next = stale_reg + STALE_W'(1);

    if (accept)
      rej_next = '0;
    else if (reject && (rej_reg != REJ_W'(REJ_LIMIT)))
      rej_next = rej_reg + REJ_W'(1);
    else
      rej_next = rej_reg;

    // An accepted sample zeroes stale_next, so it alone can never trip on stale.
    fault_trip = (stale_next == STALE_W'(STALE_LIMIT)) ||
                 (reject && (rej_next == REJ_W'(REJ_LIMIT)));

    // Readings at or below T_ON while still in RUN hold the minimum duty.
    if (last_temp_reg <= 8'(T_ON))
      run_calc = MIN_DUTY;
    else
      run_calc = MIN_DUTY + (32'(last_temp_reg) - T_ON) * STEP_PCT;
    run_duty = (run_calc >= 32'd100) ? 7'd100 : run_calc[6:0];

    ramp_tick  = (ramp_reg == RAMP_W'(RAMP_DIV - 1));
    presc_tick = (presc_reg == PRESC_W'(PWM_PRESC - 1));

    step_next  = step_reg;
    latch_next = latch_reg;
    if (presc_tick) begin
      if (step_reg == 7'd99) begin
        step_next  = 7'd0;
        latch_next = duty_reg;
      end else begin
        step_next  = step_reg + 7'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_OFF;
      fault_reg     <= 1'b0;
      last_temp_reg <= 8'd0;
    end else if (fault_trip) begin
      state_reg <= ST_FAULT;
      fault_reg <= 1'b1;
    end else if (accept) begin
      fault_reg     <= 1'b0;
      last_temp_reg <= TEMP_INT;
      case (state_reg)
        ST_OFF: begin
          if (TEMP_INT >= 8'(T_FULL))
            state_reg <= ST_FULL;
          else if (TEMP_INT >= 8'(T_ON))
            state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (TEMP_INT <= 8'(T_OFF))
            state_reg <= ST_OFF;
          else if (TEMP_INT >= 8'(T_FULL))
            state_reg <= ST_FULL;
        end
        ST_FULL: begin
          if (TEMP_INT <= T_FULL_LO)
            state_reg <= (TEMP_INT <= 8'(T_OFF)) ? ST_OFF : ST_RUN;
        end
        default: begin
          if (TEMP_INT < 8'(T_ON))
            state_reg <= ST_OFF;
          else if (TEMP_INT < 8'(T_FULL))
            state_reg <= ST_RUN;
          else
            state_reg <= ST_FULL;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stale_reg  <= '0;
      rej_reg    <= '0;
      target_reg <= 7'd0;
    end else begin
      stale_reg <= stale_next;
      rej_reg   <= rej_next;
      case (state_reg)
        ST_OFF:  target_reg <= 7'd0;
        ST_RUN:  target_reg <= run_duty;
        default: target_reg <= 7'd100;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ramp_reg <= '0;
      duty_reg <= 7'd0;
    end else begin
      ramp_reg <= ramp_tick ? '0 : ramp_reg + RAMP_W'(1);
      if (state_reg == ST_FAULT)
        duty_reg <= 7'd100;
      else if (ramp_tick) begin
        if (duty_reg < target_reg)
          duty_reg <= duty_reg + 7'd1;
        else if (duty_reg > target_reg)
          duty_reg <= duty_reg - 7'd1;
      end
    end
  end

  // Compare against the next step/latch pair so a 100% period never dips low at the wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_reg <= '0;
      step_reg  <= 7'd0;
      latch_reg <= 7'd0;
      pwm_reg   <= 1'b0;
    end else begin
      presc_reg <= presc_tick ? '0 : presc_reg + PRESC_W'(1);
      step_reg  <= step_next;
      latch_reg <= latch_next;
      pwm_reg   <= (step_next < latch_next);
    end
  end

  assign FAN_PWM   = pwm_reg;
  assign DUTY      = duty_reg;
  assign STATE_OUT = state_reg;
  assign FAULT     = fault_reg;

endmodule

// File: tb/tb_temp_fan_pwm.sv
// Directed bench for temp_fan_pwm: expectations are queued when stimulus is applied
// and popped against the DUT outputs once the response is due.
module tb_temp_fan_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] temp_int;
  logic       temp_valid;
  logic       fan_pwm;
  logic [6:0] duty;
  logic [1:0] state_out;
  logic       fault;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    value;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  temp_fan_pwm #(
    .PWM_PRESC   (2),
    .RAMP_DIV    (4),
    .STALE_LIMIT (1000)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .TEMP_INT   (temp_int),
    .TEMP_VALID (temp_valid),
    .FAN_PWM    (fan_pwm),
    .DUTY       (duty),
    .STATE_OUT  (state_out),
    .FAULT      (fault)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input string tag, input int value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic expect_pop(input logic [31:0] observed);
    exp_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d, nothing expected", observed);
    end else begin
      e = sb_q.pop_front();
      assert (observed === 32'(e.value)) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] observed, input int lo, input int hi);
    n_assert++;
    assert ((observed >= 32'(lo)) && (observed <= 32'(hi))) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  task automatic check_duty(input string tag, input int value);
    expect_push(tag, value);
    expect_pop(32'(duty));
  endtask

  // One accepted/rejected sample; state and FAULT are checked on the following edge.
  task automatic send(input int t, input int exp_state);
    temp_int   = 8'(t);
    temp_valid = 1'b1;
    expect_push($sformatf("state_after_%0d", t), exp_state);
    expect_push($sformatf("fault_after_%0d", t), (exp_state == 3) ? 1 : 0);
    tick(1);
    temp_valid = 1'b0;
    expect_pop(32'(state_out));
    expect_pop(32'(fault));
  endtask

  task automatic wait_level(input logic level, input int bound, input string tag);
    int n = 0;
    while (fan_pwm !== level && n < bound) begin
      n++;
      tick(1);
    end
    expect_push(tag, int'(level));
    expect_pop(32'(fan_pwm));
  endtask

  task automatic measure_run(input logic level, input int bound, output int len);
    len = 0;
    while (fan_pwm === level && len < bound) begin
      len++;
      tick(1);
    end
  endtask

  initial begin
    int hi, lo, n;
    rst        = 1'b1;
    temp_int   = 8'd0;
    temp_valid = 1'b0;
    tick(3);
    expect_push("reset_fan_pwm", 0);
    expect_push("reset_duty", 0);
    expect_push("reset_state", 0);
    expect_push("reset_fault", 0);
    expect_pop(32'(fan_pwm));
    expect_pop(32'(duty));
    expect_pop(32'(state_out));
    expect_pop(32'(fault));
    rst = 1'b0;

    // Hysteresis band entry and ramp toward MIN_DUTY
    send(29, 0);
    tick(99);
    send(30, 1);
    tick(2);
    check_range("duty_ramp_start", 32'(duty), 0, 1);
    tick(97);
    check_range("duty_ramp_mid", 32'(duty), 23, 26);
    send(28, 1);
    tick(60);
    check_duty("duty_settled_30", 30);

    // PWM shape at 30%: 60 high / 140 low with PWM_PRESC=2
    wait_level(1'b0, 400, "pwm_wait_low");
    wait_level(1'b1, 400, "pwm_wait_rise");
    measure_run(1'b1, 250, hi);
    measure_run(1'b0, 250, lo);
    measure_run(1'b1, 250, hi);
    expect_push("pwm_high_30", 60);
    expect_pop(32'(hi));
    measure_run(1'b0, 250, lo);
    expect_push("pwm_low_30", 140);
    expect_pop(32'(lo));

    // Drop to OFF two cycles into a period: this period keeps its latched 30%
    hi = 0;
    for (int i = 0; i < 250 && fan_pwm === 1'b1; i++) begin
      hi++;
      if (i == 1) begin
        temp_int   = 8'd27;
        temp_valid = 1'b1;
        expect_push("state_after_27_midperiod", 0);
      end
      if (i == 2) begin
        temp_valid = 1'b0;
        expect_pop(32'(state_out));
      end
      tick(1);
    end
    expect_push("pwm_high_midperiod", 60);
    expect_pop(32'(hi));
    check_range("duty_moved_midperiod", 32'(duty), 0, 29);
    n = 0;
    for (int i = 0; i < 340; i++) begin
      if (fan_pwm !== 1'b0) n++;
      tick(1);
    end
    expect_push("pwm_high_after_latch0", 0);
    expect_pop(32'(n));
    check_duty("duty_off_0", 0);

    // Linear region, FULL entry and FULL hysteresis
    send(35, 1);
    tick(300);
    check_duty("duty_run_35", 65);
    send(39, 1);
    tick(150);
    check_duty("duty_run_39", 93);
    send(40, 2);
    tick(60);
    check_duty("duty_full_40", 100);
    tick(200);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (fan_pwm !== 1'b1) n++;
      tick(1);
    end
    expect_push("pwm_low_cycles_at_100", 0);
    expect_pop(32'(n));
    send(38, 1);
    tick(70);
    check_duty("duty_run_38", 86);
    send(39, 1);
    tick(40);
    check_duty("duty_run_39_again", 93);

    // Stale expiry exactly 1000 edges after the last accepted sample
    tick(959);
    expect_push("state_before_stale", 1);
    expect_pop(32'(state_out));
    tick(1);
    expect_push("state_stale_fault", 3);
    expect_push("fault_stale", 1);
    expect_push("duty_at_fault_entry", 93);
    expect_pop(32'(state_out));
    expect_pop(32'(fault));
    expect_pop(32'(duty));
    tick(1);
    check_duty("duty_fault_jump", 100);

    send(25, 0);
    tick(10);
    check_range("duty_slew_from_fault", 32'(duty), 96, 99);

    // Reject counting: a valid reading in between resets the count
    send(70, 0);
    send(70, 0);
    send(25, 0);
    send(70, 0);
    send(70, 0);
    send(70, 3);
    tick(1);
    check_duty("duty_reject_fault", 100);

    // Accepted sample on the stale-expiry edge prevents the fault; a rejected one does not
    send(25, 0);
    tick(999);
    send(30, 1);
    tick(999);
    send(70, 3);

    // Reset in the middle of a ramp
    send(25, 0);
    tick(420);
    check_duty("duty_back_to_0", 0);
    send(33, 1);
    n = 0;
    while (duty !== 7'd50 && n < 300) begin
      n++;
      tick(1);
    end
    check_duty("duty_reached_50", 50);
    rst = 1'b1;
    tick(1);
    expect_push("midrun_reset_fan_pwm", 0);
    expect_push("midrun_reset_duty", 0);
    expect_push("midrun_reset_state", 0);
    expect_push("midrun_reset_fault", 0);
    expect_pop(32'(fan_pwm));
    expect_pop(32'(duty));
    expect_pop(32'(state_out));
    expect_pop(32'(fault));
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
